// File: rtl/ac97_link_engine.sv
// rtl/ac97_link_engine.sv - AC-link frame serialiser with command FIFO and optional register readback
// Optional feature macro: AC97_READBACK_EN (input deserialiser, codec_ready and read-response path)
module ac97_link_engine #(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 16,
  parameter int CMD_DEPTH = 4
) (
  input  logic                       ac97_bitclk,
  input  logic                       I_RESET_L,
  input  logic                       ac97_sdata_in,
  output logic                       ac97_sdata_out,
  output logic                       ac97_sync,
  output logic                       ac97_reset_b,
  output logic                       frame_strobe,
  input  logic [NUM_CH*SAMPLE_W-1:0] pcm_in,
  input  logic [NUM_CH-1:0]          pcm_valid,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_rd,
  input  logic [6:0]                 cmd_addr,
  input  logic [15:0]                cmd_data,
  output logic                       rd_valid,
  output logic [6:0]                 rd_addr,
  output logic [15:0]                rd_data,
  output logic                       codec_ready
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(CMD_DEPTH);

  logic [7:0]       cnt;
  logic             running;
  logic [255:0]     out_sr;
  logic [255:0]     frame;
  logic [23:0]      fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fill;
  logic [23:0]      head;
  logic             sample_edge;
  logic             push;
  logic             pop;

  // running is low for the reset cycles and lets cnt hold 255 through the first cycle after release
  assign sample_edge    = running && (cnt == 8'd255);
  assign cmd_ready      = running && (fill != FULL_CNT);
  assign push           = cmd_valid && cmd_ready;
  assign pop            = sample_edge && (fill != '0);
  assign head           = fifo_mem[rd_ptr];
  assign ac97_sdata_out = out_sr[255];
  assign ac97_sync      = running && ((cnt == 8'd255) || (cnt <= 8'd14));
  assign frame_strobe   = sample_edge;
  assign ac97_reset_b   = 1'b1;

  // frame[255] is output bit 0; head = {rd, addr, data}
  always_comb begin
    frame      = '0;
    frame[255] = 1'b1;
    frame[254] = pop;
    frame[253] = pop && !head[23];
    if (pop) begin
      frame[239:220] = {head[23:16], 12'h000};
      if (!head[23]) frame[219:200] = {head[15:0], 4'h0};
    end
    for (int i = 0; i < NUM_CH; i++) begin
      frame[252-i] = pcm_valid[i];
      if (pcm_valid[i])
        frame[199-20*i -: 20] = 20'(pcm_in[i*SAMPLE_W +: SAMPLE_W]) << (20 - SAMPLE_W);
    end
  end

  always_ff @(posedge ac97_bitclk) begin
    if (!I_RESET_L) begin
      cnt     <= 8'd255;
      running <= 1'b0;
      out_sr  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
    end else begin
      running <= 1'b1;
      if (running) cnt <= cnt + 8'd1;
      if (sample_edge) out_sr <= frame;
      else             out_sr <= {out_sr[254:0], 1'b0};
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fill <= fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge ac97_bitclk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_rd, cmd_addr, cmd_data};
  end

`ifdef AC97_READBACK_EN
  logic [254:0] in_sr;
  logic [255:0] in_full;
  logic         capt;

  // in_full[255] is input bit 0 once bit 255 arrives at the sampling edge
  assign in_full = {in_sr, ac97_sdata_in};

  always_ff @(posedge ac97_bitclk) begin
    if (!I_RESET_L) begin
      in_sr       <= '0;
      capt        <= 1'b0;
      codec_ready <= 1'b0;
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
      rd_data     <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (running) in_sr <= in_full[254:0];
      if (sample_edge) begin
        capt <= 1'b1;
        // capt guards against evaluating a frame that began before reset release
        if (capt) begin
          codec_ready <= in_full[255];
          if (&in_full[255:253]) begin
            rd_valid <= 1'b1;
            rd_addr  <= in_full[238:232];
            rd_data  <= in_full[219:204];
          end
        end
      end
    end
  end
`else
  logic unused_sdata_in;
  assign unused_sdata_in = ac97_sdata_in;
  assign rd_valid        = 1'b0;
  assign rd_addr         = '0;
  assign rd_data         = '0;
  assign codec_ready     = 1'b0;
`endif

endmodule

// File: tb/tb_ac97_link_engine.sv
// tb/tb_ac97_link_engine.sv - randomized self-checking bench for ac97_link_engine
// Checks every cycle against a frame-level model built from slot/tag rules and a command queue.
module tb_ac97_link_engine;
  localparam int NUM_CH = 2, SAMPLE_W = 16, CMD_DEPTH = 4;

  typedef struct packed {logic rd; logic [6:0] addr; logic [15:0] data;} cmd_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic sdi = 1'b0;
  logic sdo, sync, reset_b, strobe;
  logic [NUM_CH*SAMPLE_W-1:0] pcm_in = '0;
  logic [NUM_CH-1:0] pcm_valid = '0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic rd_valid, codec_ready;
  logic [6:0] rd_addr;
  logic [15:0] rd_data;

  ac97_link_engine #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .CMD_DEPTH(CMD_DEPTH)) dut (
    .ac97_bitclk(clk), .I_RESET_L(rst_l), .ac97_sdata_in(sdi), .ac97_sdata_out(sdo),
    .ac97_sync(sync), .ac97_reset_b(reset_b), .frame_strobe(strobe),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .codec_ready(codec_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state
  bit m_run = 0;
  int m_cnt = 255;
  cmd_t m_q[$];
  bit m_frame_live = 0;
  logic [15:0] m_tag;
  logic [19:0] m_slot [1:12];
  bit e_crdy = 0, e_rdv = 0;
  logic [6:0] e_rda = '0;
  logic [15:0] e_rdd = '0;
  bit rx [256];
  int frame_no = 0, lit_phase = 0;
  bit lit_rd_done = 0;

  // codec input frame
  bit in_live = 0;
  int in_n = 0;
  logic [15:0] in_tag;
  logic [19:0] in_slot [1:12];

  // driver state
  bit rst_want = 0, rand_cmd = 0, rand_pcm = 0, pend = 0;
  cmd_t pend_cmd;
  cmd_t script[$];

  function automatic logic in_bit(input int k);
    if (k < 16) return in_tag[15-k];
    return in_slot[(k-16)/20 + 1][19 - (k-16)%20];
  endfunction

  task automatic new_in_frame();
    in_n++;
    for (int n = 1; n <= 12; n++) in_slot[n] = 20'($urandom);
    if (in_n == 1) begin
      in_tag = 16'hE000;
      in_slot[1] = 20'hA6000;
      in_slot[2] = 20'h000F0;
    end else if (in_n == 2) begin
      in_tag = {3'b110, 13'($urandom)};
    end else begin
      in_tag = 16'($urandom);
      if ($urandom_range(0, 1) == 1) in_tag[15:13] = 3'b111;
    end
    in_live = 1;
  endtask

  task automatic compare_frame();
    logic [15:0] rx_tag;
    logic [19:0] rx_slot [1:12];
    for (int j = 0; j < 16; j++) rx_tag[15-j] = rx[j];
    for (int n = 1; n <= 12; n++)
      for (int b = 0; b < 20; b++) rx_slot[n][19-b] = rx[16 + 20*(n-1) + b];
    check("tag", rx_tag, m_tag);
    for (int n = 1; n <= 12; n++) check($sformatf("slot%0d", n), rx_slot[n], m_slot[n]);
    if (lit_phase == 1 && frame_no == 0) begin
      check("first_tag", rx_tag, 16'b1001_1000_0000_0000);
      check("first_slot3", rx_slot[3], 20'h12340);
      check("first_slot4", rx_slot[4], 20'h80000);
    end
    if (lit_phase == 1 && frame_no == 1) begin
      check("cmdA_slot1", rx_slot[1], 20'h02000);
      check("cmdA_slot2", rx_slot[2], 20'h08080);
      check("cmdA_tag12", rx_tag[14:13], 2'b11);
    end
    if (lit_phase == 1 && frame_no == 2) begin
      check("cmdB_slot1", rx_slot[1], 20'hA6000);
      check("cmdB_tag12", rx_tag[14:13], 2'b10);
    end
    if (lit_phase == 2 && frame_no == 0) check("post_reset_tag12", rx_tag[14:13], 2'b00);
    frame_no++;
  endtask

  task automatic check_cycle();
    check("sync", sync, m_run && (m_cnt == 255 || m_cnt <= 14));
    check("frame_strobe", strobe, m_run && m_cnt == 255);
    check("cmd_ready", cmd_ready, m_run && m_q.size() < CMD_DEPTH);
    check("rd_valid", rd_valid, e_rdv);
    check("rd_addr", rd_addr, e_rda);
    check("rd_data", rd_data, e_rdd);
    check("codec_ready", codec_ready, e_crdy);
    if (!m_run) check("sdata_idle", sdo, 1'b0);
    else begin
      rx[m_cnt] = sdo;
      if (m_cnt == 255 && m_frame_live) compare_frame();
    end
`ifdef AC97_READBACK_EN
    if (e_rdv && !lit_rd_done) begin
      check("rd_addr_first", rd_addr, 7'h26);
      check("rd_data_first", rd_data, 16'h000F);
      check("codec_ready_first", codec_ready, 1'b1);
      lit_rd_done = 1;
    end
`endif
  endtask

  task automatic drive();
    rst_l = rst_want;
    if (!rst_want) begin
      pend = 0;
      cmd_valid = 0;
    end else begin
      if (!pend) begin
        if (script.size() > 0) begin
          pend_cmd = script.pop_front();
          pend = 1;
        end else if (rand_cmd && $urandom_range(0, 5) == 0) begin
          pend_cmd = 24'($urandom);
          pend = 1;
        end
      end
      cmd_valid = pend;
      cmd_rd = pend_cmd.rd;
      cmd_addr = pend_cmd.addr;
      cmd_data = pend_cmd.data;
    end
    if (rand_pcm) begin
      pcm_in = 32'($urandom);
      pcm_valid = 2'($urandom);
    end
    if (m_run && m_cnt == 0) new_in_frame();
    sdi = in_live ? in_bit(m_cnt) : 1'($urandom_range(0, 1));
  endtask

  // predicts the effect of the coming rising edge from the inputs just driven
  task automatic model_next();
    int sz;
    bit popd;
    cmd_t c;
    logic [SAMPLE_W-1:0] smp;
    if (!rst_l) begin
      m_run = 0; m_cnt = 255; m_q.delete(); m_frame_live = 0; in_live = 0;
      e_crdy = 0; e_rdv = 0; e_rda = '0; e_rdd = '0;
    end else if (!m_run) begin
      m_run = 1; m_cnt = 255;
    end else begin
      sz = m_q.size();
      e_rdv = 0;
      if (m_cnt == 255) begin
        popd = sz > 0;
        c = '0;
        if (popd) c = m_q.pop_front();
        m_tag = '0;
        m_tag[15] = 1'b1;
        m_tag[14] = popd;
        m_tag[13] = popd && !c.rd;
        for (int n = 1; n <= 12; n++) m_slot[n] = '0;
        if (popd) m_slot[1] = {c.rd, c.addr, 12'h000};
        if (popd && !c.rd) m_slot[2] = {c.data, 4'h0};
        for (int i = 0; i < NUM_CH; i++) begin
          m_tag[12-i] = pcm_valid[i];
          smp = pcm_in[i*SAMPLE_W +: SAMPLE_W];
          if (pcm_valid[i]) m_slot[3+i] = 20'(smp) * (20'd1 << (20 - SAMPLE_W));
        end
        m_frame_live = 1;
`ifdef AC97_READBACK_EN
        if (in_live) begin
          e_crdy = in_tag[15];
          if (in_tag[15:13] == 3'b111) begin
            e_rdv = 1;
            e_rda = in_slot[1][18:12];
            e_rdd = in_slot[2][19:4];
          end
        end
`endif
      end
      if (cmd_valid && sz < CMD_DEPTH) begin
        m_q.push_back({cmd_rd, cmd_addr, cmd_data});
        pend = 0;
      end
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive();
    model_next();
  endtask

  initial begin
    pcm_in = {16'h8000, 16'h1234};
    pcm_valid = 2'b11;
    repeat (4) step();
    rst_want = 1;
    lit_phase = 1;
    frame_no = 0;
    step();
    step();
    script.push_back('{rd: 1'b0, addr: 7'h02, data: 16'h0808});
    script.push_back('{rd: 1'b1, addr: 7'h26, data: 16'h0000});
    for (int k = 0; k < CMD_DEPTH - 1; k++) script.push_back(24'($urandom));
    while (frame_no < 3) step();
    rand_pcm = 1;
    rand_cmd = 1;
    while (frame_no < 9) step();

    rand_cmd = 0;
    while (m_q.size() != 0 || pend) step();
    while (m_cnt != 0) step();
    script.push_back(24'($urandom));
    script.push_back(24'($urandom));
    while (m_cnt != 100) step();
    rst_want = 0;
    repeat (4) step();
    lit_phase = 2;
    frame_no = 0;
    rst_want = 1;
    rand_cmd = 1;
    while (frame_no < 4) step();
    check("reset_b", reset_b, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ac97_link_engine.md
# ac97_link_engine

Parametrised AC-link controller: serialises one 256-bit AC'97 output frame per 48 kHz frame period from up to ten PCM channels and a queued codec-register command stream. When readback is compiled in, it also deserialises the codec's input frame to return register-read responses. Sits between the sound channel mixers / register-config logic and the codec pins, clocked by the codec's 12.288 MHz bit clock.

## Interface
- NUM_CH, 2: PCM output channels, 1..10. Channel i is carried in slot 3+i.
- SAMPLE_W, 16: sample width, 1..20. Sample is left-justified in the 20-bit slot; unused LSBs are 0.
- CMD_DEPTH, 4: command FIFO entries, power of 2, ≥2.
- ac97_bitclk  in  1  sole clock, rising edge only.
- I_RESET_L  in  1  reset, synchronous, active-low.
- ac97_sdata_in  in  1  codec serial data.
- ac97_sdata_out  out  1  serial frame data, driven from a flop.
- ac97_sync  out  1  frame sync.
- ac97_reset_b  out  1  constant 1; codec cold reset is external.
- frame_strobe  out  1  one-cycle pulse marking the frame input-sampling edge.
- pcm_in  in  NUM_CH*SAMPLE_W  samples; channel 0 is in the LSBs.
- pcm_valid  in  NUM_CH  per-channel slot-valid.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  FIFO not full.
- cmd_rd  in  1  1 = register read, 0 = write.
- cmd_addr  in  7  codec register address.
- cmd_data  in  16  write data.
- rd_valid  out  1  one-cycle read-response pulse.
- rd_addr  out  7  response address.
- rd_data  out  16  response data.
- codec_ready  out  1  input tag bit 0 of the last complete frame.

## Operation
- Bit counter cnt runs 0..255 and wraps 255→0. Output frame bit k (bit 0 = tag MSB) is on ac97_sdata_out during the cycle with cnt==k.
- ac97_sync = 1 when cnt==255 or cnt≤14; otherwise 0.
- frame_strobe = 1 during cnt==255. pcm_in, pcm_valid and the FIFO head are sampled at the edge ending that cycle, and that content forms the next frame.
- Tag bits:
  - bit 0 = 1.
  - bit 1 = command popped.
  - bit 2 = popped command is a write.
  - bit 3+i = pcm_valid[i].
  - all other tag bits = 0.
- Any invalid slot carries 20'h0.
- Command FIFO:
  - Push on cmd_valid && cmd_ready.
  - One entry is popped per frame at the sampling edge if the FIFO is non-empty.
  - Slot 1 = {cmd_rd, cmd_addr, 12'h000}.
  - Slot 2 = {cmd_data, 4'h0} for writes only.
  - A push at the sampling edge into an empty FIFO is not popped until the following frame.
  - When full, cmd_ready=0. A pop frees one entry, and cmd_ready rises on the cycle after the pop edge.
  - Entries are sent in FIFO order with no drops and no duplicates.
- Input capture (readback):
  - Input bit k is sampled at the edge ending cnt==k.
  - At the edge ending cnt==255, codec_ready is updated to input bit 0.
  - If input bits 0, 1 and 2 are all 1, rd_valid pulses during the next cnt==0 cycle with rd_addr = in_slot1[18:12] and rd_data = in_slot2[19:4].
  - rd_addr and rd_data hold until the next response.
- Reset (I_RESET_L=0 at an edge):
  - cnt=255 is loaded and the FIFO is flushed.
  - ac97_sdata_out, ac97_sync, frame_strobe, cmd_ready, rd_valid, rd_addr, rd_data and codec_ready are all 0 while in reset.
  - A reset mid-frame aborts the frame with no partial-frame readback.

## Timing
- First cycle after reset release: cnt==255, ac97_sync=1, frame_strobe=1, cmd_ready=1.
- Latency from the sampling edge to tag bit 0 on the pin is 1 cycle (the cnt==0 cycle).
- Slot n, n≥1, occupies cnt 16+20(n-1) .. 35+20(n-1), MSB first.
- Command latency: a push accepted ≥1 cycle before the sampling edge into an empty FIFO appears in slot 1 ≤1 cycle later.
- Read-response latency is 1 frame: a read sent in frame N is answered by the codec in input frame N+1, and rd_valid pulses at cnt==0 of frame N+2.
- Throughput: 1 command per frame, NUM_CH samples per frame.

## Configuration
- AC97_READBACK_EN defined: input deserialiser, codec_ready and read-response path are built as above.
- AC97_READBACK_EN undefined: ac97_sdata_in is ignored, and rd_valid, rd_addr, rd_data and codec_ready are tied to 0. The output path is unchanged.

## Test plan
- Reset release, NUM_CH=2, pcm_in={16'h8000,16'h1234}, pcm_valid=2'b11 → first frame tag = 16'b1001_1000_0000_0000, slot3 = 20'h12340, slot4 = 20'h80000, sync high cnt 255..14.
- Push write addr 7'h02, data 16'h0808, plus read addr 7'h26 → frame A slot1 = 20'h02000, slot2 = 20'h08080, tag bits 1,2 = 1,1. Frame B slot1 = 20'hA6000, tag bits 1,2 = 1,0.
- Push CMD_DEPTH+1 commands back-to-back with no frame boundary → cmd_ready drops after the 4th push. The 5th push is held, accepted 1 cycle after the next pop, and all 5 are transmitted in order.
- Codec model returns input tag 3'b111, slot1 = 20'hA6000, slot2 = 20'h000F0 → rd_valid one cycle at cnt==0 of the next frame, rd_addr=7'h26, rd_data=16'h000F, codec_ready=1.
- Input tag bit 2 = 0 → no rd_valid, rd_addr/rd_data unchanged. With AC97_READBACK_EN undefined, rd_valid is never asserted.
- Assert I_RESET_L=0 at cnt==100 with 2 FIFO entries → all outputs 0. After release the first frame has tag bits 1,2 = 0 (FIFO flushed) and cnt restarts at 255.
